// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the RV32I core blocks (decoder, writeback mux,
// integer register file).
//
// Contents:
//   XLEN        architectural data width
//   REG_ADDR_W  register index width
//   REG_ZERO    index of the hard-wired zero register x0
//   REG_SP      index of the stack pointer x2
//   RF_SP_INIT  value loaded into sp when the register file resets
//   word_t      one XLEN-wide data word
//   reg_idx_t   one register index
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

  // Top of the on-chip data RAM, word aligned.
  localparam logic [XLEN-1:0] RF_SP_INIT = 32'h0000_03FC;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: integer register file for the single-cycle RV32I core.
// 2**ADDR_W registers of XLEN bits. It has two combinational read ports and one
// synchronous write port. x0 reads as zero and ignores writes.
//
// Parameters:
//   XLEN     data width (default 32)
//   ADDR_W   register index width (default 5)
//   SP_INIT  reset value of x2 (sp)
//
// Ports:
//   clk        core clock; state changes on the rising edge
//   rst        synchronous active-high reset; takes priority over a write
//   rs1_addr   read port 1 index
//   rs2_addr   read port 2 index
//   rd_addr    write index
//   wr_data    write data from the writeback mux
//   reg_write  write enable
//   rs1_data   contents of rs1_addr (combinational)
//   rs2_data   contents of rs2_addr (combinational)
//
// Optional build macro RF_DEBUG_EN adds:
//   dbg_addr   third read port index (board display / bench)
//   dbg_data   contents of dbg_addr (combinational, same x0 rule)
//   wr_count   number of committed writes; cleared by rst; wraps around
module reg_file
  import riscv_pkg::*;
#(
  parameter int              XLEN    = riscv_pkg::XLEN,
  parameter int              ADDR_W  = riscv_pkg::REG_ADDR_W,
  parameter logic [XLEN-1:0] SP_INIT = RF_SP_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              reg_write,
`ifdef RF_DEBUG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [31:0]       wr_count,
`endif
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       commit;

  // Index 0 is decoded here, so the result never depends on what regs[0] holds.
  function automatic logic [XLEN-1:0] read_port(
    input logic [NREGS-1:0][XLEN-1:0] r,
    input logic [ADDR_W-1:0]          a
  );
    return (a == '0) ? '0 : r[a];
  endfunction

  assign commit = reg_write && (rd_addr != '0);

  // Reset is checked first, so a write in the same cycle is discarded.
  // When reg_write is low, wr_data is never sampled, so X on it has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs                     <= '0;
      regs[ADDR_W'(REG_SP)]    <= SP_INIT;
    end else if (commit) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // The read ports have no write bypass. In a single-cycle core a bypass would
  // close a combinational loop through the ALU and the writeback mux. A read of
  // the register being written returns the old value until the edge.
  assign rs1_data = read_port(regs, rs1_addr);
  assign rs2_data = read_port(regs, rs2_addr);

`ifdef RF_DEBUG_EN
  assign dbg_data = read_port(regs, dbg_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule
